// File: rtl/rdy_vld_pkg.sv
// rdy_vld_pkg: sizing helpers shared by the ready/valid upsizer and its lane accumulator
package rdy_vld_pkg;
  function automatic int safe_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rdy_vld_upsizer_acc.sv
// rdy_vld_upsizer_acc: stores the RATIO-1 partial lanes of the word being assembled
module rdy_vld_upsizer_acc import rdy_vld_pkg::*; #(
  parameter int DWIDTH = 32,
  parameter int RATIO = 4,
  localparam int LW = (RATIO > 1) ? RATIO - 1 : 1,
  localparam int IW = safe_clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IW-1:0]        lane,
  input  logic [DWIDTH-1:0]    din,
  input  logic                 clear,
  output logic [LW*DWIDTH-1:0] lanes
);
  logic [LW*DWIDTH-1:0] lanes_d, lanes_q;
  always_comb begin
    lanes_d = clear ? '0 : lanes_q;
    for (int j = 0; j < LW; j++)
      if (wr_en && lane == IW'(j)) lanes_d[j*DWIDTH +: DWIDTH] = din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lanes_q <= '0;
    else lanes_q <= lanes_d;
  assign lanes = lanes_q;
endmodule

// File: rtl/rdy_vld_upsizer.sv
// rdy_vld_upsizer: packs RATIO narrow beats into one registered wide word;
// RDY_VLD_UPSIZER_LAST_EN adds last_in/last_out/keep_out packet framing
module rdy_vld_upsizer import rdy_vld_pkg::*; #(
  parameter int DWIDTH = 32,
  parameter int RATIO = 4,
  localparam int OWIDTH = DWIDTH * RATIO,
  localparam int CW = safe_clog2(RATIO),
  localparam int LW = (RATIO > 1) ? RATIO - 1 : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_in,
  input  logic [DWIDTH-1:0] din,
  output logic              rdy_out,
  output logic              vld_out,
  output logic [OWIDTH-1:0] dout,
  input  logic              rdy_in
`ifdef RDY_VLD_UPSIZER_LAST_EN
  ,
  input  logic              last_in,
  output logic              last_out,
  output logic [RATIO-1:0]  keep_out
`endif
);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_BEAT = cnt_t'(RATIO - 1);
  cnt_t cnt_d, cnt_q;
  logic vld_d, vld_q;
  logic [OWIDTH-1:0] dout_d, dout_q, word, acc_x;
  logic [LW*DWIDTH-1:0] acc;
  logic fin, in_xfer, load;
`ifdef RDY_VLD_UPSIZER_LAST_EN
  logic last_d, last_q;
  logic [RATIO-1:0] keep_d, keep_q;
  assign fin = (cnt_q == LAST_BEAT) | (vld_in & last_in);
`else
  assign fin = cnt_q == LAST_BEAT;
`endif
  // only a word-closing beat can be blocked, and only by an undrained held word
  assign rdy_out = ~fin | ~vld_q | rdy_in;
  assign in_xfer = vld_in & rdy_out;
  assign load = in_xfer & fin;
  assign acc_x = OWIDTH'(acc);
  rdy_vld_upsizer_acc #(.DWIDTH(DWIDTH), .RATIO(RATIO)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(in_xfer & ~fin),
    .lane(cnt_q),
    .din(din),
    .clear(load),
    .lanes(acc)
  );
  // lanes below the closing beat come from the accumulator, lanes above it are zero
  always_comb begin
    word = '0;
    for (int j = 0; j < RATIO; j++)
      word[j*DWIDTH +: DWIDTH] = (cnt_q == cnt_t'(j)) ? din :
                                 (cnt_q > cnt_t'(j)) ? acc_x[j*DWIDTH +: DWIDTH] : '0;
    cnt_d = in_xfer ? (fin ? '0 : cnt_q + 1'b1) : cnt_q;
    vld_d = load | (vld_q & ~rdy_in);
    dout_d = load ? word : dout_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
      dout_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      dout_q <= dout_d;
    end
  assign vld_out = vld_q;
  assign dout = dout_q;
`ifdef RDY_VLD_UPSIZER_LAST_EN
  always_comb begin
    keep_d = keep_q;
    for (int j = 0; j < RATIO; j++) if (load) keep_d[j] = cnt_t'(j) <= cnt_q;
    last_d = load ? last_in : last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      keep_q <= keep_d;
      last_q <= last_d;
    end
  assign keep_out = keep_q;
  assign last_out = last_q;
`endif
endmodule
